md_stall_ctrl: RTL

Pipeline sequencing controller for the dynamic pipeline. It generates the write-enable and stall controls for PC, IF/ID, ID/EX and EX/MEM. It holds multi-cycle MUL/DIV instructions in EX for a fixed, parameterised latency and inserts load-use bubbles into ID/EX. It sits beside the hazard/forwarding logic and drives the `wena`/`stall` inputs of the pipeline registers directly.

---
 rtl/md_stall_ctrl_pkg.sv | 25 ++
 rtl/md_latency_counter.sv | 31 +++
 rtl/md_stall_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/md_stall_ctrl_pkg.sv
// Shared constants for the MUL/DIV stall controller: FSM encoding, kind
// encoding, default latencies and pipeline-register enable levels.
package md_stall_ctrl_pkg;

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  localparam logic MD_KIND_MUL = 1'b0;
  localparam logic MD_KIND_DIV = 1'b1;

  localparam int MD_MUL_CYCLES_DEF = 4;
  localparam int MD_DIV_CYCLES_DEF = 33;

  // Levels for pipeline-register write enables
  localparam logic STOP          = 1'b0;
  localparam logic WRITE_ENABLED = 1'b1;

  // Counter width: holds LAT-2 of the longer operation, never below 1 bit
  function automatic int md_cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter tracking remaining freeze cycles of a MUL/DIV in EX.
// Load has priority over decrement; the count saturates at zero.
module md_latency_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load, else decrement while non-zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  // Count register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/md_stall_ctrl.sv
// Pipeline sequencing controller: holds MUL/DIV in EX for a fixed latency
// (freezing PC, IF/ID, ID/EX and bubbling EX/MEM) and, when the macro
// MD_LOAD_USE_STALL_EN is defined, inserts a one-cycle load-use bubble
// into ID/EX. Without the macro the load-use term is constant 0.
module md_stall_ctrl
  import md_stall_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [4:0] exe_rf_waddr,
  input  logic       exe_rf_wena,
  input  logic       exe_load,
  input  logic       exe_mul_ena,
  input  logic       exe_div_ena,
  output logic       pc_wena,
  output logic       if_id_wena,
  output logic       id_ex_wena,
  output logic       id_ex_stall,
  output logic       ex_mem_bubble,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done
);

  localparam int CW = md_cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 2);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 2);

  logic [0:0]    state_q, state_d;
  logic          kind_q, kind_d;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_load_val;
  logic          freeze, load_use;
  logic          start_c, busy_c, done_c;

  md_latency_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // MD sequencing: IDLE detects a MUL/DIV in EX, BUSY counts down to done
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = MUL_LOAD;
    start_c      = 1'b0;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    freeze       = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (exe_mul_ena | exe_div_ena) begin
          start_c      = 1'b1;
          busy_c       = 1'b1;
          freeze       = 1'b1;
          cnt_load     = 1'b1;
          // DIV wins when both enables are high
          cnt_load_val = exe_div_ena ? DIV_LOAD : MUL_LOAD;
          kind_d       = exe_div_ena ? MD_KIND_DIV : MD_KIND_MUL;
          state_d      = MD_BUSY;
        end
      end
      MD_BUSY: begin
        busy_c = 1'b1;
        if (!cnt_zero) begin
          freeze  = 1'b1;
          cnt_dec = 1'b1;
        end else begin
          // Last EX cycle: the instruction advances at this edge
          done_c  = 1'b1;
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // FSM and kind registers; reset returns to IDLE even mid-operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      kind_q  <= MD_KIND_MUL;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  // Kind is kept for observability/debug; nothing downstream consumes it
  logic unused_kind;
  assign unused_kind = kind_q;

`ifdef MD_LOAD_USE_STALL_EN
  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    load_use = exe_load & exe_rf_wena & (exe_rf_waddr != 5'd0) &
               ((id_rs_used & (id_rs_addr == exe_rf_waddr)) |
                (id_rt_used & (id_rt_addr == exe_rf_waddr)));
  end
`else
  assign load_use = 1'b0;
  logic unused_lu;
  assign unused_lu = ^{id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
                       exe_rf_waddr, exe_rf_wena, exe_load};
`endif

  // Output mux: reset forcing > MD freeze > load-use > normal flow
  always_comb begin
    pc_wena       = WRITE_ENABLED;
    if_id_wena    = WRITE_ENABLED;
    id_ex_wena    = WRITE_ENABLED;
    id_ex_stall   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_start      = 1'b0;
    md_busy       = 1'b0;
    md_done       = 1'b0;
    if (!rst) begin
      md_start = start_c;
      md_busy  = busy_c;
      md_done  = done_c;
      if (freeze) begin
        pc_wena       = STOP;
        if_id_wena    = STOP;
        id_ex_wena    = STOP;
        ex_mem_bubble = 1'b1;
      end else if (load_use) begin
        pc_wena     = STOP;
        if_id_wena  = STOP;
        id_ex_stall = 1'b1;
      end
    end
  end

endmodule
